timer_alarm: RTL
================

// Module: timer_alarm
// PURPOSE
//  Millisecond alarm/interrupt unit directly downstream of the free-running ms timer.
//  Consumes the timer's 32-bit ms count (time_in) and holds a CPU-programmable compare value.
//  Raises a level interrupt when the count reaches the compare value; one-shot or periodic.
//  Register file is written and read over the CPU register bus; read port A is tri-state.
// PARAMETERS
//  WIDTH  32  width of time_in, CMP and PERIOD; compare arithmetic is modulo 2^WIDTH
// PORTS
//  clk         in   1      system clock (the same clock as the ms timer)
//  rst_n       in   1      reset: asynchronous, active-low
//  time_in     in   WIDTH  ms count from the timer's data_out; changes only on clk edges
//  wr_en       in   1      register write strobe, sampled on posedge clk
//  wr_sel      in   2      write target: 0=CMP 1=PERIOD 2=CTRL 3=STATUS
//  wr_data     in   32     write data
//  rd_A_en     in   1      read enable, bus A
//  rd_A_sel    in   2      read select; same map as wr_sel
//  data_A_out  out  32     selected register when rd_A_en=1, else 32'bz (combinational)
//  irq_ack     in   1      1-cycle pulse; clears the pending flag
//  irq         out  1      interrupt request, level, registered
// BEHAVIOUR
//  Reset: CMP=0, PERIOD=0, CTRL=0, pending=0, overrun=0, FSM=IDLE, irq=0.
//    data_A_out is z unless rd_A_en=1. Reset asserted mid-operation aborts at once to these values.
//  Registers:
//    CTRL[0]=enable, CTRL[1]=periodic; other CTRL bits are read as 0.
//    STATUS reads {28'b0, state[1:0], overrun, pending}.
//    A STATUS write with bit0=1 clears pending; with bit1=1 clears overrun (write-1-to-clear).
//  Writes take effect on the clock edge that samples wr_en; new values are visible to the compare on the next cycle.
//  due = ($signed(time_in - CMP) >= 0), computed at WIDTH bits.
//    Wrap-safe: correct across 2^WIDTH rollover when CMP is within 2^(WIDTH-1) ms ahead of time_in.
//  FSM states IDLE, ARMED, FIRED:
//    IDLE  -> ARMED on the cycle after CTRL.enable is written to 1.
//    ARMED -> FIRED when due=1. fire_evt is asserted for that one cycle.
//    FIRED -> ARMED on the next cycle if periodic=1 and PERIOD!=0; CMP <= CMP+PERIOD (wraps modulo 2^WIDTH).
//    FIRED -> IDLE otherwise (one-shot); CTRL.enable self-clears.
//    Any state -> IDLE when CTRL.enable is written to 0. pending and overrun are preserved.
//    A write to CMP while ARMED re-evaluates due on the next cycle.
//      If the new CMP is already in the past, the alarm fires immediately.
//  Latency: time_in reaches CMP in cycle N -> pending=1 and irq=1 in cycle N+1.
//  On fire_evt: pending <= 1. If pending was already 1, overrun <= 1 as well.
//  Periodic catch-up: if CMP+PERIOD is still due, the alarm fires again 2 cycles later, which sets overrun.
//  irq = pending & CTRL.enable, registered. Disabling the block drops irq on the next cycle; pending stays readable.
//  Simultaneous events:
//    fire_evt together with irq_ack or a STATUS clear in the same cycle -> set wins (pending=1, no lost interrupt).
//    A CPU write to CMP together with the periodic CMP update in the same cycle -> the CPU write wins.
//  Reads: pure mux of the registered state; no side effects on read.
// STRUCTURE
//  Shared package/header (timer_pkg):
//    register select codes (SEL_CMP, SEL_PERIOD, SEL_CTRL, SEL_STATUS)
//    CTRL/STATUS bit indices
//    FSM state encoding (IDLE=2'd0, ARMED=2'd1, FIRED=2'd2)
//  Single module. The wrap-safe compare (time_in, CMP -> due) may be a sub-module alarm_cmp.
//  The register file and FSM stay in timer_alarm.
// TESTING
//  1 One-shot: CMP=100, CTRL=1, time_in steps 98..102
//    -> irq rises the cycle after time_in=100; state IDLE; CTRL.enable=0; pending=1.
//  2 Periodic: CMP=10, PERIOD=5, CTRL=3, ack each irq
//    -> fires at time_in=10, 15, 20; CMP reads 25 after the third fire; overrun=0.
//  3 Wrap: time_in=32'hFFFF_FFFE, CMP=32'h0000_0001, enable
//    -> no fire at FFFF_FFFE/FFFF_FFFF; fires on the cycle after time_in=1.
//  4 Overrun and race: leave pending=1 unacked, next periodic fire -> STATUS=0b11 (overrun, pending).
//    Then irq_ack in the same cycle as a fire -> pending remains 1.
//  5 Past compare: time_in=500, write CMP=400 while ARMED -> fires within 2 cycles.
//    Disable mid-ARMED -> irq=0 next cycle, state IDLE.
//  6 Reset mid-FIRED: assert rst_n=0 asynchronously -> irq=0, all registers 0, data_A_out=z with rd_A_en=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the millisecond alarm unit: register map, bit positions, FSM encoding.
package timer_pkg;

  localparam logic [1:0] SEL_CMP    = 2'd0;
  localparam logic [1:0] SEL_PERIOD = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_PER_BIT   = 1;
  localparam int unsigned STATUS_PND_BIT = 0;
  localparam int unsigned STATUS_OVR_BIT = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StFired = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/alarm_cmp.sv
// Wrap-safe "time has reached compare" test: the modular difference is read as a signed value.
module alarm_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] time_in,
  input  logic [WIDTH-1:0] cmp,
  output logic             due
);

  logic signed [WIDTH-1:0] diff;

  assign diff = time_in - cmp;
  assign due  = (diff >= $signed({WIDTH{1'b0}}));

endmodule

// File: rtl/timer_alarm.sv
// Millisecond alarm unit: CPU register file, one-shot/periodic alarm FSM and level interrupt.
module timer_alarm
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] time_in,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [31:0]      wr_data,
  input  logic             rd_A_en,
  input  logic [1:0]       rd_A_sel,
  output logic [31:0]      data_A_out,
  input  logic             irq_ack,
  output logic             irq
);

  alarm_state_e     state_q, state_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             en_q, en_d;
  logic             per_q, per_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             irq_q;
  logic             due;
  logic             fire_evt;
  logic             wr_cmp, wr_period, wr_ctrl, wr_status;
  logic [31:0]      rd_data;

  alarm_cmp #(
    .WIDTH (WIDTH)
  ) u_alarm_cmp (
    .time_in (time_in),
    .cmp     (cmp_q),
    .due     (due)
  );

  assign wr_cmp    = wr_en && (wr_sel == SEL_CMP);
  assign wr_period = wr_en && (wr_sel == SEL_PERIOD);
  assign wr_ctrl   = wr_en && (wr_sel == SEL_CTRL);
  assign wr_status = wr_en && (wr_sel == SEL_STATUS);

  assign fire_evt = (state_q == StArmed) && due;

  always_comb begin
    state_d  = state_q;
    cmp_d    = cmp_q;
    period_d = period_q;
    en_d     = en_q;
    per_d    = per_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (en_q) state_d = StArmed;
      end
      StArmed: begin
        if (due) state_d = StFired;
      end
      StFired: begin
        if (per_q && (period_q != '0)) begin
          state_d = StArmed;
          cmp_d   = cmp_q + period_q;
        end else begin
          state_d = StIdle;
          en_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // CPU writes are applied after the FSM so they win over the periodic reload.
    if (wr_cmp)    cmp_d    = wr_data[WIDTH-1:0];
    if (wr_period) period_d = wr_data[WIDTH-1:0];
    if (wr_ctrl) begin
      en_d  = wr_data[CTRL_EN_BIT];
      per_d = wr_data[CTRL_PER_BIT];
      if (!wr_data[CTRL_EN_BIT]) state_d = StIdle;
    end

    if (irq_ack || (wr_status && wr_data[STATUS_PND_BIT])) pend_d = 1'b0;
    if (wr_status && wr_data[STATUS_OVR_BIT])              ovr_d  = 1'b0;
    // Set after clear so a fire coinciding with an ack is never lost.
    if (fire_evt) begin
      pend_d = 1'b1;
      if (pend_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cmp_q    <= '0;
      period_q <= '0;
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmp_q    <= cmp_d;
      period_q <= period_d;
      en_q     <= en_d;
      per_q    <= per_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      // Built from next-state values so irq shows up in the cycle right after the fire.
      irq_q    <= pend_d & en_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_A_sel)
      SEL_CMP:    rd_data = 32'(cmp_q);
      SEL_PERIOD: rd_data = 32'(period_q);
      SEL_CTRL:   rd_data = {30'b0, per_q, en_q};
      SEL_STATUS: rd_data = {28'b0, state_q, ovr_q, pend_q};
      default:    rd_data = '0;
    endcase
  end

  assign data_A_out = rd_A_en ? rd_data : 32'bz;
  assign irq        = irq_q;

endmodule
